// File: rtl/nested_irq_unit.sv
// Nested, vectored interrupt unit: falling-edge capture on active-low sources,
// priority arbitration, and a return-PC/level stack so higher priorities preempt.
module nested_irq_unit #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_W     = 3,
    parameter int NEST_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_sources,
    input  logic               stall,
    input  logic               end_isr,
    input  logic [31:0]        pc_next,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic               irq_take,
    output logic [31:0]        irq_target,
    output logic [5:0]         irq_id,
    output logic               irq_ret,
    output logic [31:0]        irq_ret_pc,
    output logic [PRIO_W-1:0]  irq_level,
    output logic [4:0]         irq_depth
);

    localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] fall;
    logic [NUM_SRC-1:0] clear;
    logic [PRIO_W-1:0]  prio   [NUM_SRC];
    logic [31:0]        target [NUM_SRC];
    logic [31:0]        stack_pc  [NEST_DEPTH];
    logic [PRIO_W-1:0]  stack_lvl [NEST_DEPTH];
    logic [4:0]         depth;
    logic [PRIO_W-1:0]  cur_level;

    logic               found;
    logic [IW-1:0]      win_idx;
    logic [PRIO_W-1:0]  best_prio;
    logic [SW-1:0]      top_idx;
    logic [SW-1:0]      push_idx;

    // Strictly-greater compare while scanning upward keeps the lowest index on ties.
    // A source can only win with prio > cur_level, so prio 0 never qualifies.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > cur_level) &&
                (!found || (prio[i] > best_prio))) begin
                found     = 1'b1;
                win_idx   = IW'(i);
                best_prio = prio[i];
            end
        end
    end

    assign top_idx  = SW'(depth - 5'd1);
    assign push_idx = SW'(depth);

    assign irq_ret    = end_isr & ~stall & (depth != 5'd0);
    assign irq_take   = found & ~stall & ~irq_ret & (depth < 5'(NEST_DEPTH));
    assign irq_target = irq_take ? target[win_idx] : 32'd0;
    assign irq_id     = irq_take ? 6'(win_idx) : 6'd0;
    assign irq_ret_pc = irq_ret ? stack_pc[top_idx] : 32'd0;
    assign irq_level  = cur_level;
    assign irq_depth  = depth;

    assign fall  = prev_src & ~irq_sources;
    assign clear = irq_take ? (NUM_SRC'(1) << win_idx) : '0;

    // A fresh edge on the winning source in the take cycle survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_src <= '1;
            pending  <= '0;
        end else begin
            prev_src <= irq_sources;
            pending  <= (pending & ~clear) | fall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth     <= 5'd0;
            cur_level <= '0;
            for (int d = 0; d < NEST_DEPTH; d++) begin
                stack_pc[d]  <= 32'd0;
                stack_lvl[d] <= '0;
            end
        end else if (irq_take) begin
            stack_pc[push_idx]  <= pc_next;
            stack_lvl[push_idx] <= cur_level;
            depth               <= depth + 5'd1;
            cur_level           <= prio[win_idx];
        end else if (irq_ret) begin
            depth     <= depth - 5'd1;
            cur_level <= stack_lvl[top_idx];
        end
    end

    // Addresses at or beyond 2*NUM_SRC match no source and are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i]   <= '0;
                target[i] <= 32'd0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cfg_addr == 8'(2 * i)) begin
                    target[i] <= cfg_wdata;
                end
                if (cfg_addr == 8'(2 * i + 1)) begin
                    enable[i] <= cfg_wdata[31];
                    prio[i]   <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_nested_irq_unit.sv
// Bench for nested_irq_unit: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the interrupt rules.
module tb_nested_irq_unit;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_sources = '1;
    logic          stall = 1'b0;
    logic          end_isr = 1'b0;
    logic [31:0]   pc_next = 32'd0;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_addr = 8'd0;
    logic [31:0]   cfg_wdata = 32'd0;
    logic          irq_take;
    logic [31:0]   irq_target;
    logic [5:0]    irq_id;
    logic          irq_ret;
    logic [31:0]   irq_ret_pc;
    logic [PW-1:0] irq_level;
    logic [4:0]    irq_depth;

    nested_irq_unit #(.NUM_SRC(N), .PRIO_W(PW), .NEST_DEPTH(ND)) dut (
        .clk(clk), .reset(reset), .irq_sources(irq_sources), .stall(stall),
        .end_isr(end_isr), .pc_next(pc_next), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .irq_take(irq_take), .irq_target(irq_target),
        .irq_id(irq_id), .irq_ret(irq_ret), .irq_ret_pc(irq_ret_pc),
        .irq_level(irq_level), .irq_depth(irq_depth)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]   pc;
        logic [PW-1:0] lvl;
    } frame_t;

    logic [N-1:0]  m_prev;
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_en;
    logic [PW-1:0] m_prio [N];
    logic [31:0]   m_tgt  [N];
    logic [PW-1:0] m_level;
    frame_t        m_stk[$];
    logic [N-1:0]  cur_src;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_prev  = '1;
        m_pend  = '0;
        m_en    = '0;
        m_level = '0;
        for (int i = 0; i < N; i++) begin
            m_prio[i] = '0;
            m_tgt[i]  = 32'd0;
        end
        m_stk.delete();
    endtask

    // Drive one cycle of inputs, compare the combinational and registered outputs
    // with the model, then advance the model across the clock edge.
    task automatic applyStimulus(input logic [N-1:0] src, input logic st, input logic eisr,
                                 input logic [31:0] pc, input logic we, input logic [7:0] addr,
                                 input logic [31:0] wd);
        bit          e_take, e_ret, found;
        int          w, best, k;
        logic [31:0] e_ret_pc;
        frame_t      f;
        @(negedge clk);
        irq_sources = src;
        stall       = st;
        end_isr     = eisr;
        pc_next     = pc;
        cfg_we      = we;
        cfg_addr    = addr;
        cfg_wdata   = wd;
        #1;
        e_ret = eisr && !st && (m_stk.size() != 0);
        found = 0;
        w     = 0;
        best  = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && m_prio[i] != 0 && m_prio[i] > m_level &&
                int'(m_prio[i]) > best) begin
                found = 1;
                w     = i;
                best  = int'(m_prio[i]);
            end
        end
        e_take   = found && !st && !e_ret && (m_stk.size() < ND);
        e_ret_pc = 32'd0;
        if (e_ret) e_ret_pc = m_stk[m_stk.size()-1].pc;
        checkOutput("irq_take",   32'(irq_take),   32'(e_take));
        checkOutput("irq_target", irq_target,      e_take ? m_tgt[w] : 32'd0);
        checkOutput("irq_id",     32'(irq_id),     e_take ? 32'(w) : 32'd0);
        checkOutput("irq_ret",    32'(irq_ret),    32'(e_ret));
        checkOutput("irq_ret_pc", irq_ret_pc,      e_ret_pc);
        checkOutput("irq_level",  32'(irq_level),  32'(m_level));
        checkOutput("irq_depth",  32'(irq_depth),  32'(m_stk.size()));
        @(posedge clk);
        if (e_take) begin
            f.pc  = pc;
            f.lvl = m_level;
            m_stk.push_back(f);
            m_level   = m_prio[w];
            m_pend[w] = 1'b0;
        end else if (e_ret) begin
            f       = m_stk.pop_back();
            m_level = f.lvl;
        end
        m_pend = m_pend | (m_prev & ~src);
        m_prev = src;
        if (we && int'(addr) < 2 * N) begin
            k = int'(addr) / 2;
            if (addr[0]) begin
                m_en[k]   = wd[31];
                m_prio[k] = wd[PW-1:0];
            end else begin
                m_tgt[k] = wd;
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        irq_sources = '1;
        stall       = 1'b0;
        end_isr     = 1'b0;
        pc_next     = 32'd0;
        cfg_we      = 1'b0;
        cfg_addr    = 8'd0;
        cfg_wdata   = 32'd0;
        cur_src     = '1;
        #1;
        checkOutput("rst_take",   32'(irq_take),  32'd0);
        checkOutput("rst_target", irq_target,     32'd0);
        checkOutput("rst_id",     32'(irq_id),    32'd0);
        checkOutput("rst_ret",    32'(irq_ret),   32'd0);
        checkOutput("rst_ret_pc", irq_ret_pc,     32'd0);
        checkOutput("rst_level",  32'(irq_level), 32'd0);
        checkOutput("rst_depth",  32'(irq_depth), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input logic [31:0] pc);
        for (int c = 0; c < n; c++) applyStimulus(cur_src, 1'b0, 1'b0, pc, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic cfgWrite(input int addr, input logic [31:0] data);
        applyStimulus(cur_src, 1'b0, 1'b0, 32'h0, 1'b1, 8'(addr), data);
    endtask

    task automatic endIsr(input logic [31:0] pc);
        applyStimulus(cur_src, 1'b0, 1'b1, pc, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic configAll();
        for (int i = 0; i < N; i++) begin
            cfgWrite(2 * i, $urandom() & 32'hFFFF_FFFC);
            cfgWrite(2 * i + 1, (($urandom_range(3) != 0) ? 32'h8000_0000 : 32'd0) |
                                32'($urandom_range(7)));
        end
    endtask

    initial begin
        cur_src = '1;
        modelReset();
        doReset();

        // Single source entry and return with literal expectations.
        cfgWrite(4, 32'h0000_0100);
        cfgWrite(5, 32'h8000_0003);
        idle(3, 32'h3C);
        cur_src[2] = 1'b0;
        applyStimulus(cur_src, 1'b0, 1'b0, 32'h40, 1'b0, 8'd0, 32'd0);
        applyStimulus(cur_src, 1'b0, 1'b0, 32'h40, 1'b0, 8'd0, 32'd0);
        #1;
        checkOutput("plan1_level", 32'(irq_level), 32'd3);
        checkOutput("plan1_depth", 32'(irq_depth), 32'd1);
        cur_src[2] = 1'b1;
        idle(2, 32'h104);
        endIsr(32'h108);
        #1;
        checkOutput("plan1_ret_level", 32'(irq_level), 32'd0);
        checkOutput("plan1_ret_depth", 32'(irq_depth), 32'd0);

        // Equal priorities: lower index first, other one after the return.
        cfgWrite(2, 32'h0000_0200);
        cfgWrite(3, 32'h8000_0002);
        cfgWrite(10, 32'h0000_0500);
        cfgWrite(11, 32'h8000_0002);
        cur_src[1] = 1'b0;
        cur_src[5] = 1'b0;
        idle(3, 32'h80);
        endIsr(32'h204);
        idle(2, 32'h84);
        endIsr(32'h504);
        cur_src = '1;
        idle(2, 32'h88);

        // Preemption by a higher level, same-level request waits for both returns.
        cfgWrite(8, 32'h0000_0400);
        cfgWrite(9, 32'h8000_0005);
        cfgWrite(12, 32'h0000_0600);
        cfgWrite(13, 32'h8000_0002);
        cur_src[1] = 1'b0;
        idle(2, 32'h90);
        cur_src[4] = 1'b0;
        idle(2, 32'h94);
        cur_src[6] = 1'b0;
        idle(2, 32'h98);
        endIsr(32'h404);
        idle(1, 32'h208);
        endIsr(32'h20C);
        idle(2, 32'h9C);
        endIsr(32'h604);
        cur_src = '1;
        idle(2, 32'hA0);

        // Edge during a two-cycle stall is taken once the stall drops.
        cfgWrite(0, 32'h0000_0700);
        cfgWrite(1, 32'h8000_0007);
        cur_src[0] = 1'b0;
        applyStimulus(cur_src, 1'b1, 1'b0, 32'hB0, 1'b0, 8'd0, 32'd0);
        applyStimulus(cur_src, 1'b1, 1'b0, 32'hB0, 1'b0, 8'd0, 32'd0);
        idle(2, 32'hB4);
        endIsr(32'h704);

        // Return at depth 0 is ignored; out-of-range config writes do nothing.
        endIsr(32'hC0);
        cfgWrite(2 * N, 32'hFFFF_FFFF);
        cfgWrite(2 * N + 1, 32'hFFFF_FFFF);
        cur_src = '1;
        idle(2, 32'hC4);

        // Random traffic, with one reset in the middle of activity.
        configAll();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                doReset();
                configAll();
            end
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) cur_src[b] = ~cur_src[b];
            end
            applyStimulus(cur_src, $urandom_range(99) < 15, $urandom_range(99) < 12,
                          32'($urandom()) & 32'hFFFF_FFFC, $urandom_range(99) < 3,
                          8'($urandom_range(2 * N + 3)), 32'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
